matmul_result_drain: RTL

//   Downstream stage of MatrixMultiply. Captures the full N x N result matrix c

---
 rtl/matmul_result_drain.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/matmul_result_drain.sv
// Captures the N x N result of MatrixMultiply on a rising complete and drains it
// row-major, one element per beat, over a registered valid/ready stream.
module matmul_result_drain #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [0:N-1][0:N-1][W-1:0]   c,
  input  logic                         complete,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [W-1:0]                 out_data,
  output logic [IW-1:0]                out_row,
  output logic [IW-1:0]                out_col,
  output logic                         out_last,
  output logic                         busy,
  output logic                         overrun,
  output logic [7:0]                   frame_count
);

  localparam int NN   = N * N;
  localparam int IDXW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NN - 1);
  localparam logic [IDXW-1:0] N_L      = IDXW'(N);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t                       state_q;
  logic [IDXW-1:0]              idx_q;
  logic                         complete_q;
  logic [0:N-1][0:N-1][W-1:0]   buf_q;
  logic                         out_valid_q;
  logic [W-1:0]                 out_data_q;
  logic [IW-1:0]                out_row_q;
  logic [IW-1:0]                out_col_q;
  logic                         out_last_q;
  logic                         overrun_q;
  logic [7:0]                   frame_count_q;

  logic                         rise_d;
  logic                         fire_d;
  logic                         final_fire_d;
  logic [IDXW-1:0]              idx_inc_d;
  logic [IW-1:0]                row_inc_d;
  logic [IW-1:0]                col_inc_d;

  function automatic logic [IW-1:0] row_of(input logic [IDXW-1:0] idx);
    return IW'(idx / N_L);
  endfunction

  function automatic logic [IW-1:0] col_of(input logic [IDXW-1:0] idx);
    return IW'(idx % N_L);
  endfunction

  // Handshake and next-beat index decode, all from registered state.
  always_comb begin
    rise_d       = complete & ~complete_q;
    fire_d       = out_valid_q & out_ready;
    final_fire_d = fire_d & (idx_q == LAST_IDX);
    idx_inc_d    = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
    row_inc_d    = row_of(idx_inc_d);
    col_inc_d    = col_of(idx_inc_d);
  end

  // Capture/stream FSM; every output is a register loaded one edge ahead.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= {IDXW{1'b0}};
      complete_q    <= 1'b0;
      buf_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= {W{1'b0}};
      out_row_q     <= {IW{1'b0}};
      out_col_q     <= {IW{1'b0}};
      out_last_q    <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      complete_q <= complete;
      case (state_q)
        S_IDLE: begin
          if (rise_d) begin
            state_q     <= S_STREAM;
            buf_q       <= c;
            idx_q       <= {IDXW{1'b0}};
            out_valid_q <= 1'b1;
            out_data_q  <= c[0][0];
            out_row_q   <= {IW{1'b0}};
            out_col_q   <= {IW{1'b0}};
            out_last_q  <= (LAST_IDX == {IDXW{1'b0}});
          end else begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        S_STREAM: begin
          if (final_fire_d) begin
            frame_count_q <= frame_count_q + 8'd1;
            idx_q         <= {IDXW{1'b0}};
            out_row_q     <= {IW{1'b0}};
            out_col_q     <= {IW{1'b0}};
            // A fresh result landing on the closing beat chains straight on.
            if (rise_d) begin
              state_q     <= S_STREAM;
              buf_q       <= c;
              out_valid_q <= 1'b1;
              out_data_q  <= c[0][0];
              out_last_q  <= (LAST_IDX == {IDXW{1'b0}});
            end else begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end
          end else if (fire_d) begin
            idx_q      <= idx_inc_d;
            out_data_q <= buf_q[row_inc_d][col_inc_d];
            out_row_q  <= row_inc_d;
            out_col_q  <= col_inc_d;
            out_last_q <= (idx_inc_d == LAST_IDX);
            if (rise_d) begin
              overrun_q <= 1'b1;
            end else begin
              overrun_q <= overrun_q;
            end
          end else begin
            if (rise_d) begin
              overrun_q <= 1'b1;
            end else begin
              overrun_q <= overrun_q;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          idx_q       <= {IDXW{1'b0}};
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_row     = out_row_q;
  assign out_col     = out_col_q;
  assign out_last    = out_last_q;
  assign busy        = (state_q == S_STREAM);
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule
